// File: rtl/bridge_pkg.sv
// Shared types and ASCII constants for the UART-to-bus request parser.
package bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StEnd
  } bridge_state_t;

  localparam logic [7:0] CHAR_R  = 8'h52;
  localparam logic [7:0] CHAR_W  = 8'h57;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/hex_decoder.sv
// Combinational ASCII hex digit decoder.
// BRIDGE_RX_LOWERCASE_HEX_EN additionally accepts 'a'-'f'.
module hex_decoder (
  input  logic [7:0] ascii_i,
  output logic [3:0] nibble_o,
  output logic       is_hex_o
);

  always_comb begin
    nibble_o = 4'h0;
    is_hex_o = 1'b0;
    if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
      nibble_o = ascii_i[3:0];
      is_hex_o = 1'b1;
    end else if (ascii_i >= 8'h41 && ascii_i <= 8'h46) begin
      // 'A' has low nibble 1, so +9 yields 10
      nibble_o = ascii_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end
`ifdef BRIDGE_RX_LOWERCASE_HEX_EN
    else if (ascii_i >= 8'h61 && ascii_i <= 8'h66) begin
      nibble_o = ascii_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/bridge_rx.sv
// Parses "R<addr>\r" / "W<addr><data>\r" ASCII messages into bus requests.
// Lowercase hex acceptance is controlled by BRIDGE_RX_LOWERCASE_HEX_EN (see hex_decoder).
module bridge_rx
  import bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rw_o,
  output logic                  valid_o,
  output logic                  err_o
);

  localparam int unsigned NumAddr   = ADDR_WIDTH / 4;
  localparam int unsigned NumData   = DATA_WIDTH / 4;
  localparam int unsigned MaxDigits = (NumAddr > NumData) ? NumAddr : NumData;
  localparam int unsigned CntWidth  = $clog2(MaxDigits + 1);

  localparam logic [CntWidth-1:0] LastAddr = CntWidth'(NumAddr - 1);
  localparam logic [CntWidth-1:0] LastData = CntWidth'(NumData - 1);

  bridge_state_t         state;
  logic [CntWidth-1:0]   cnt;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] data_sh;
  logic                  rw;

  logic [3:0] nibble;
  logic       is_hex;
  logic       is_cmd;
  logic       is_term;
  logic       bad;

  hex_decoder u_hex_decoder (
    .ascii_i  (data_i),
    .nibble_o (nibble),
    .is_hex_o (is_hex)
  );

  assign is_cmd  = (data_i == CHAR_R) || (data_i == CHAR_W);
  assign is_term = (data_i == CHAR_CR) || (data_i == CHAR_LF);

  always_comb begin
    bad = 1'b0;
    unique case (state)
      StAddr, StData: bad = !is_hex;
      StEnd:          bad = !is_term;
      default:        bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      cnt     <= '0;
      addr_sh <= '0;
      data_sh <= '0;
      rw      <= 1'b0;
      addr_o  <= '0;
      data_o  <= '0;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      if (valid_i) begin
        if (bad) begin
          err_o <= 1'b1;
          cnt   <= '0;
          state <= StIdle;
        end else begin
          unique case (state)
            StIdle: ;
            StAddr: begin
              addr_sh <= (addr_sh << 4) | ADDR_WIDTH'(nibble);
              if (cnt == LastAddr) begin
                cnt   <= '0;
                state <= rw ? StData : StEnd;
              end else begin
                cnt <= cnt + CntWidth'(1);
              end
            end
            StData: begin
              data_sh <= (data_sh << 4) | DATA_WIDTH'(nibble);
              if (cnt == LastData) begin
                cnt   <= '0;
                state <= StEnd;
              end else begin
                cnt <= cnt + CntWidth'(1);
              end
            end
            StEnd: begin
              addr_o  <= addr_sh;
              data_o  <= rw ? data_sh : '0;
              rw_o    <= rw;
              valid_o <= 1'b1;
              cnt     <= '0;
              state   <= StIdle;
            end
            default: state <= StIdle;
          endcase
        end
        // A command letter mid-message resynchronises instead of being lost
        if (is_cmd && (state == StIdle || bad)) begin
          addr_sh <= '0;
          data_sh <= '0;
          rw      <= (data_i == CHAR_W);
          cnt     <= '0;
          state   <= StAddr;
        end
      end
    end
  end

endmodule
